// File: rtl/fifo_credit_based.sv
// Per-input-port receive FIFO for the credit-based router: show-ahead head flit to all
// output crossbars, one registered credit pulse upstream per consumed flit.
module fifo_credit_based #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  valid_in,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  credit_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic                  overflow_err,
  output logic [DATA_WIDTH-1:0] Data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W:0]        r_count;
  logic                  r_credit;
  logic                  r_overflow;

  logic [4:0]            w_read_vec;
  logic                  w_read_req;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [PTR_W:0]        w_count_next;

  assign w_read_vec = {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L};
  // Several output ports asserting together still consume only the single head flit.
  assign w_read_req = |w_read_vec;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = w_read_req & ~w_empty;
  // A full FIFO can still accept a write when the head is leaving in the same cycle.
  assign w_push  = valid_in & (~w_full | w_pop);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_credit   <= w_pop;
      r_overflow <= valid_in & w_full & ~w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_mem[gi] <= '0;
        end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_mem[gi] <= RX;
        end
      end
    end
  endgenerate

  assign Data_out     = r_mem[r_rd_ptr];
  assign empty_out    = w_empty;
  assign full_out     = w_full;
  assign credit_out   = r_credit;
  assign overflow_err = r_overflow;

endmodule
